// File: rtl/sw_reg_responder.sv
// -----------------------------------------------------------------------------
// sw_reg_responder
//
// Switch-side responder for the address decoder's switch interface. Each
// instance models one switch: a small register bank answered after a fixed
// access latency. rd_data_out from every instance is OR-combined at top level,
// so an instance drives zero on rd_data_out except during the ack of a read.
//
// Parameters:
//   SW_ID        - switch index, returned (truncated) by reads of register 0
//   W_WIDTH      - data and address width
//   NUM_REGS     - register-bank depth, power of two, at least 2
//   ACCESS_DELAY - wait cycles between request capture and ack (0 allowed)
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   sel_en_in   - one-cycle request strobe
//   wr_rd_s_in  - 1 = write, 0 = read (valid with sel_en_in)
//   addr_in     - register address, low bits index the bank (valid with sel_en_in)
//   wr_data_in  - write data (valid with sel_en_in)
//   ack_out     - one-cycle completion pulse
//   rd_data_out - read data, nonzero only in the ack cycle of a read
//   busy_out    - high while a request is outstanding (state != IDLE)
//   err_out     - sticky: a request arrived while busy
// -----------------------------------------------------------------------------
module sw_reg_responder #(
  parameter int SW_ID        = 0,
  parameter int W_WIDTH      = 8,
  parameter int NUM_REGS     = 16,
  parameter int ACCESS_DELAY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_en_in,
  input  logic               wr_rd_s_in,
  input  logic [W_WIDTH-1:0] addr_in,
  input  logic [W_WIDTH-1:0] wr_data_in,
  output logic               ack_out,
  output logic [W_WIDTH-1:0] rd_data_out,
  output logic               busy_out,
  output logic               err_out
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = (ACCESS_DELAY < 1) ? 1 : $clog2(ACCESS_DELAY + 1);
  localparam logic [W_WIDTH-1:0] ID_VALUE = W_WIDTH'(SW_ID);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(ACCESS_DELAY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nextState;

  logic                 r_isWrite;
  logic [IDX_W-1:0]     r_idx;
  logic [W_WIDTH-1:0]   r_wrData;
  logic [CNT_W-1:0]     r_cnt;
  logic [W_WIDTH-1:0]   r_bank [NUM_REGS];
  logic                 r_ack;
  logic [W_WIDTH-1:0]   r_rdData;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_enterAck;
  logic [IDX_W-1:0]     w_inIdx;
  logic                 w_reqWrite;
  logic [IDX_W-1:0]     w_reqIdx;
  logic [W_WIDTH-1:0]   w_reqData;
  logic [W_WIDTH-1:0]   w_readValue;
  logic                 w_unusedAddr;

  // Only the low address bits select a register; the upper bits alias.
  assign w_inIdx      = addr_in[IDX_W-1:0];
  assign w_unusedAddr = ^addr_in;

  // Next-state decode. A strobe is only accepted in IDLE; strobes seen in
  // any other state are collisions handled by the error flag below. The
  // counter holds the remaining wait cycles, so WAIT exits when it hits 1.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (sel_en_in) begin
          w_accept = 1'b1;
          if (ACCESS_DELAY == 0) begin
            w_nextState = S_ACK;
          end else begin
            w_nextState = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_nextState = S_ACK;
        end
      end
      S_ACK: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // With zero delay the bank access happens on the same edge that captures
  // the request, so the live inputs are used instead of the captured copy.
  // In IDLE without a strobe the mux output is never consumed, which keeps
  // don't-care inputs out of the state.
  assign w_enterAck  = (w_nextState == S_ACK);
  assign w_reqWrite  = (r_state == S_IDLE) ? wr_rd_s_in : r_isWrite;
  assign w_reqIdx    = (r_state == S_IDLE) ? w_inIdx    : r_idx;
  assign w_reqData   = (r_state == S_IDLE) ? wr_data_in : r_wrData;
  assign w_readValue = (w_reqIdx == '0) ? ID_VALUE : r_bank[w_reqIdx];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Request capture and wait counter. The counter is loaded with the full
  // delay on acceptance and counts down once per WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_isWrite <= 1'b0;
      r_idx     <= '0;
      r_wrData  <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_isWrite <= wr_rd_s_in;
      r_idx     <= w_inIdx;
      r_wrData  <= wr_data_in;
      r_cnt     <= CNT_LOAD;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Register bank and registered ack/read data. The access is performed on
  // the edge entering ACK; register 0 is read-only, so writes to it are
  // dropped while still being acknowledged. Read data is cleared every cycle
  // it is not being presented, keeping the shared OR bus clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_bank[i] <= '0;
      end
      r_ack    <= 1'b0;
      r_rdData <= '0;
    end else begin
      r_ack    <= w_enterAck;
      r_rdData <= '0;
      if (w_enterAck) begin
        if (w_reqWrite) begin
          if (w_reqIdx != '0) begin
            r_bank[w_reqIdx] <= w_reqData;
          end
        end else begin
          r_rdData <= w_readValue;
        end
      end
    end
  end

  // Sticky collision flag: any strobe while busy, including the ACK cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (sel_en_in && busy_out) begin
      r_err <= 1'b1;
    end
  end

  assign ack_out     = r_ack;
  assign rd_data_out = r_rdData;
  assign busy_out    = (r_state != S_IDLE);
  assign err_out     = r_err;

endmodule

// File: tb/tb_sw_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_sw_reg_responder
//
// Self-checking bench for sw_reg_responder. Three instances with different
// access delays (2, 4, 0) share clock and reset. A transaction-level model
// (per-instance register array, sticky error bit, and "free at cycle" timing
// arithmetic) provides every expected value.
// -----------------------------------------------------------------------------
module tb_sw_reg_responder;

  localparam int NI = 3;

  logic       clk;
  logic       rst;
  logic       sel   [NI];
  logic       wr    [NI];
  logic [7:0] addr  [NI];
  logic [7:0] wdata [NI];
  logic       ack   [NI];
  logic [7:0] rd    [NI];
  logic       busy  [NI];
  logic       err   [NI];

  logic [7:0] mBank [NI][16];
  bit         mErr  [NI];

  int nChecks;
  int nErrors;

  bit         tWr   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] tAddr [6] = '{8'h05, 8'h05, 8'h00, 8'h00, 8'h12, 8'h02};
  logic [7:0] tData [6] = '{8'hA5, 8'h00, 8'hFF, 8'h00, 8'h3C, 8'h00};

  sw_reg_responder #(.SW_ID(3), .W_WIDTH(8), .NUM_REGS(16), .ACCESS_DELAY(2)) dut0 (
    .clk(clk), .rst(rst), .sel_en_in(sel[0]), .wr_rd_s_in(wr[0]), .addr_in(addr[0]),
    .wr_data_in(wdata[0]), .ack_out(ack[0]), .rd_data_out(rd[0]), .busy_out(busy[0]),
    .err_out(err[0]));

  sw_reg_responder #(.SW_ID(32'h1A7), .W_WIDTH(8), .NUM_REGS(16), .ACCESS_DELAY(4)) dut1 (
    .clk(clk), .rst(rst), .sel_en_in(sel[1]), .wr_rd_s_in(wr[1]), .addr_in(addr[1]),
    .wr_data_in(wdata[1]), .ack_out(ack[1]), .rd_data_out(rd[1]), .busy_out(busy[1]),
    .err_out(err[1]));

  sw_reg_responder #(.SW_ID(5), .W_WIDTH(8), .NUM_REGS(16), .ACCESS_DELAY(0)) dut2 (
    .clk(clk), .rst(rst), .sel_en_in(sel[2]), .wr_rd_s_in(wr[2]), .addr_in(addr[2]),
    .wr_data_in(wdata[2]), .ack_out(ack[2]), .rd_data_out(rd[2]), .busy_out(busy[2]),
    .err_out(err[2]));

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dlyOf(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int swIdOf(input int k);
    case (k)
      0:       return 3;
      1:       return 32'h1A7;
      default: return 5;
    endcase
  endfunction

  // Reference access: 16-entry bank indexed by address modulo 16, entry 0
  // reads the switch id and ignores writes. Returns the expected read data.
  function automatic logic [7:0] modelAccess(input int k, input bit isWr,
                                             input logic [7:0] a, input logic [7:0] d);
    int idx;
    idx = int'(a) % 16;
    if (isWr) begin
      if (idx != 0) mBank[k][idx] = d;
      return 8'h00;
    end
    if (idx == 0) return 8'(swIdOf(k));
    return mBank[k][idx];
  endfunction

  function automatic void clearModel();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) mBank[k][i] = 8'h00;
      mErr[k] = 1'b0;
    end
  endfunction

  // Idle drive: strobe low with random junk on the qualified inputs.
  task automatic driveIdle(input int k);
    sel[k]   = 1'b0;
    wr[k]    = 1'($urandom_range(0, 1));
    addr[k]  = 8'($urandom);
    wdata[k] = 8'($urandom);
  endtask

  task automatic doReset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) driveIdle(k);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    clearModel();
  endtask

  // One request on instance k, then observe DELAY+3 cycles and report what
  // was seen. Called and returns at 1 ns after a rising edge.
  task automatic applyStimulus(input int k, input bit isWr, input logic [7:0] a,
                               input logic [7:0] d, output int ackAt, output int ackCnt,
                               output int busyCnt, output logic [7:0] rdAck, output bit leak);
    sel[k]   = 1'b1;
    wr[k]    = isWr;
    addr[k]  = a;
    wdata[k] = d;
    @(posedge clk);
    #1;
    driveIdle(k);
    ackAt   = -1;
    ackCnt  = 0;
    busyCnt = 0;
    rdAck   = 8'h00;
    leak    = 1'b0;
    for (int i = 1; i <= dlyOf(k) + 3; i++) begin
      if (ack[k] === 1'b1) begin
        ackCnt++;
        ackAt = i;
        rdAck = rd[k];
      end else if (rd[k] !== 8'h00) begin
        leak = 1'b1;
      end
      if (busy[k] === 1'b1) busyCnt++;
      driveIdle(k);
      @(posedge clk);
      #1;
    end
  endtask

  // After reset every output of every instance stays low for 10 idle cycles.
  task automatic test_reset();
    doReset();
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < NI; k++) begin
        nChecks++;
        if (ack[k] !== 1'b0) begin
          nErrors++;
          $display("[TB] FAIL reset_ack inst %0d cycle %0d: got %0b expected 0", k, c, ack[k]);
        end
        nChecks++;
        if (rd[k] !== 8'h00) begin
          nErrors++;
          $display("[TB] FAIL reset_rd inst %0d cycle %0d: got %0h expected 00", k, c, rd[k]);
        end
        nChecks++;
        if (busy[k] !== 1'b0) begin
          nErrors++;
          $display("[TB] FAIL reset_busy inst %0d cycle %0d: got %0b expected 0", k, c, busy[k]);
        end
        nChecks++;
        if (err[k] !== 1'b0) begin
          nErrors++;
          $display("[TB] FAIL reset_err inst %0d cycle %0d: got %0b expected 0", k, c, err[k]);
        end
        driveIdle(k);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Directed write/read, read-only register 0 and aliasing, then random
  // isolated accesses; checks latency, busy width, data and bus cleanliness.
  task automatic test_access(input int k);
    bit         isWr;
    logic [7:0] a, d, expRd, rdAck;
    int         ackAt, ackCnt, busyCnt;
    bit         leak;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) begin
        isWr = tWr[i];
        a    = tAddr[i];
        d    = tData[i];
      end else begin
        isWr = 1'($urandom_range(0, 1));
        a    = 8'($urandom_range(0, 40));
        d    = 8'($urandom);
      end
      expRd = modelAccess(k, isWr, a, d);
      applyStimulus(k, isWr, a, d, ackAt, ackCnt, busyCnt, rdAck, leak);
      nChecks++;
      if (ackCnt !== 1 || ackAt !== dlyOf(k) + 1) begin
        nErrors++;
        $display("[TB] FAIL access_ack inst %0d op %0d: got %0d acks at offset %0d, expected 1 at %0d",
                 k, i, ackCnt, ackAt, dlyOf(k) + 1);
      end
      nChecks++;
      if (rdAck !== expRd) begin
        nErrors++;
        $display("[TB] FAIL access_rd inst %0d op %0d addr %0h: got %0h expected %0h",
                 k, i, a, rdAck, expRd);
      end
      nChecks++;
      if (busyCnt !== dlyOf(k) + 1) begin
        nErrors++;
        $display("[TB] FAIL access_busy inst %0d op %0d: got %0d cycles expected %0d",
                 k, i, busyCnt, dlyOf(k) + 1);
      end
      nChecks++;
      if (leak !== 1'b0) begin
        nErrors++;
        $display("[TB] FAIL access_rdleak inst %0d op %0d: got nonzero rd_data outside ack, expected zero",
                 k, i);
      end
    end
    nChecks++;
    if (err[k] !== mErr[k]) begin
      nErrors++;
      $display("[TB] FAIL access_err inst %0d: got %0b expected %0b", k, err[k], mErr[k]);
    end
  endtask

  // Second strobe one cycle after the first: ignored, single ack, sticky err.
  task automatic test_collision();
    logic [7:0] expRd, rdAck;
    int         ackAt, ackCnt, busyCnt;
    bit         leak;
    logic       expErr;
    doReset();
    void'(modelAccess(0, 1'b1, 8'h09, 8'h22));
    sel[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h09; wdata[0] = 8'h22;
    @(posedge clk);
    #1;
    ackCnt = 0;
    ackAt  = -1;
    for (int i = 1; i <= 6; i++) begin
      if (ack[0] === 1'b1) begin
        ackCnt++;
        ackAt = i;
      end
      expErr = (i >= 2);
      nChecks++;
      if (err[0] !== expErr) begin
        nErrors++;
        $display("[TB] FAIL collision_err offset %0d: got %0b expected %0b", i, err[0], expErr);
      end
      if (i == 1) begin
        sel[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h07; wdata[0] = 8'h11;
        mErr[0] = 1'b1;
      end else begin
        driveIdle(0);
      end
      @(posedge clk);
      #1;
    end
    nChecks++;
    if (ackCnt !== 1 || ackAt !== dlyOf(0) + 1) begin
      nErrors++;
      $display("[TB] FAIL collision_ack: got %0d acks at offset %0d, expected 1 at %0d",
               ackCnt, ackAt, dlyOf(0) + 1);
    end
    expRd = modelAccess(0, 1'b0, 8'h07, 8'h00);
    applyStimulus(0, 1'b0, 8'h07, 8'h00, ackAt, ackCnt, busyCnt, rdAck, leak);
    nChecks++;
    if (rdAck !== expRd) begin
      nErrors++;
      $display("[TB] FAIL collision_ignored_write: got %0h expected %0h", rdAck, expRd);
    end
    expRd = modelAccess(0, 1'b0, 8'h09, 8'h00);
    applyStimulus(0, 1'b0, 8'h09, 8'h00, ackAt, ackCnt, busyCnt, rdAck, leak);
    nChecks++;
    if (rdAck !== expRd) begin
      nErrors++;
      $display("[TB] FAIL collision_first_write: got %0h expected %0h", rdAck, expRd);
    end
    nChecks++;
    if (err[0] !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL collision_err_sticky: got %0b expected 1", err[0]);
    end
  endtask

  // Reset while instance 1 (delay 4) is waiting: request dropped, no ack,
  // and the write never lands.
  task automatic test_reset_mid();
    logic [7:0] expRd, rdAck;
    int         ackAt, ackCnt, busyCnt;
    bit         leak;
    sel[1] = 1'b1; wr[1] = 1'b1; addr[1] = 8'h04; wdata[1] = 8'h77;
    @(posedge clk);
    #1;
    driveIdle(1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
    for (int c = 0; c < 8; c++) begin
      nChecks++;
      if (busy[1] !== 1'b0) begin
        nErrors++;
        $display("[TB] FAIL resetmid_busy cycle %0d: got %0b expected 0", c, busy[1]);
      end
      nChecks++;
      if (ack[1] !== 1'b0) begin
        nErrors++;
        $display("[TB] FAIL resetmid_ack cycle %0d: got %0b expected 0", c, ack[1]);
      end
      driveIdle(1);
      @(posedge clk);
      #1;
    end
    expRd = modelAccess(1, 1'b0, 8'h04, 8'h00);
    applyStimulus(1, 1'b0, 8'h04, 8'h00, ackAt, ackCnt, busyCnt, rdAck, leak);
    nChecks++;
    if (rdAck !== expRd || ackCnt !== 1) begin
      nErrors++;
      $display("[TB] FAIL resetmid_read: got %0h (%0d acks) expected %0h (1 ack)",
               rdAck, ackCnt, expRd);
    end
  endtask

  // Cycle-by-cycle traffic against the timing model: a strobe at cycle c is
  // accepted when c >= freeAt, acks at c+1+DELAY and frees the slot at
  // c+2+DELAY; a refused strobe sets err from c+1. Greedy mode strobes at
  // every earliest legal cycle, random mode strobes at random (collisions).
  task automatic test_traffic(input int k, input int n, input bit greedy);
    int         freeAt, busyStart, ackCycle, errFrom;
    logic [7:0] ackVal, opA, opD, expRd;
    bit         doSel, opWr;
    logic       expAck, expBusy, expErr;
    freeAt    = 0;
    busyStart = 0;
    ackCycle  = -1;
    ackVal    = 8'h00;
    errFrom   = mErr[k] ? 0 : 32'h7FFF_FFFF;
    for (int c = 0; c < n + dlyOf(k) + 3; c++) begin
      expAck  = (c == ackCycle);
      expRd   = expAck ? ackVal : 8'h00;
      expBusy = (c >= busyStart) && (c < freeAt);
      expErr  = (c >= errFrom);
      nChecks++;
      if (ack[k] !== expAck) begin
        nErrors++;
        $display("[TB] FAIL traffic_ack inst %0d cycle %0d: got %0b expected %0b", k, c, ack[k], expAck);
      end
      nChecks++;
      if (rd[k] !== expRd) begin
        nErrors++;
        $display("[TB] FAIL traffic_rd inst %0d cycle %0d: got %0h expected %0h", k, c, rd[k], expRd);
      end
      nChecks++;
      if (busy[k] !== expBusy) begin
        nErrors++;
        $display("[TB] FAIL traffic_busy inst %0d cycle %0d: got %0b expected %0b", k, c, busy[k], expBusy);
      end
      nChecks++;
      if (err[k] !== expErr) begin
        nErrors++;
        $display("[TB] FAIL traffic_err inst %0d cycle %0d: got %0b expected %0b", k, c, err[k], expErr);
      end
      driveIdle(k);
      if (c < n) begin
        doSel = greedy ? (c >= freeAt) : ($urandom_range(0, 3) == 0);
        if (doSel) begin
          opWr = 1'($urandom_range(0, 1));
          opA  = 8'($urandom_range(0, 47));
          opD  = 8'($urandom);
          sel[k] = 1'b1; wr[k] = opWr; addr[k] = opA; wdata[k] = opD;
          if (c >= freeAt) begin
            busyStart = c + 1;
            ackCycle  = c + 1 + dlyOf(k);
            freeAt    = c + 2 + dlyOf(k);
            ackVal    = modelAccess(k, opWr, opA, opD);
          end else begin
            if (errFrom > c + 1) errFrom = c + 1;
            mErr[k] = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    test_traffic(2, 40, 1'b1);
    test_traffic(0, 40, 1'b1);
    test_traffic(1, 40, 1'b1);
  endtask

  task automatic test_random_traffic();
    for (int k = 0; k < NI; k++) test_traffic(k, 300, 1'b0);
  endtask

  // Test sequence and summary.
  initial begin
    nChecks = 0;
    nErrors = 0;
    rst     = 1'b1;
    for (int k = 0; k < NI; k++) begin
      sel[k] = 1'b0; wr[k] = 1'b0; addr[k] = 8'h00; wdata[k] = 8'h00;
    end
    clearModel();
    $display("[TB] starting");
    test_reset();
    for (int k = 0; k < NI; k++) test_access(k);
    test_collision();
    test_reset_mid();
    test_back_to_back();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
